// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the 32-bit MIPS datapath.
// Handles MULT/MULTU with shift-add and DIV/DIVU with restoring division,
// one bit per clock, plus the MTHI/MTLO register writes.
module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              mthi_we,
  input  logic              mtlo_we,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_op;
  logic                r_sign_a;
  logic                r_sign_b;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_sh;
  logic [DATA_W-1:0]   r_rem;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_done;

  // Magnitude of a value; only signed ops treat the MSB as a sign bit.
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] f_abs(input logic [DATA_W-1:0] v,
                                              input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? -v : v;
  endfunction

  // Two's complement negation applied only when the result sign must flip.
  function automatic logic [DATA_W-1:0] f_neg_if(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    return neg ? -v : v;
  endfunction

  logic                w_signed_op;
  logic [DATA_W-1:0]   w_abs_a;
  logic [DATA_W-1:0]   w_abs_b;
  logic [DATA_W:0]     w_mul_sum;
  logic [DATA_W:0]     w_rem_sh;
  logic [DATA_W-1:0]   w_diff;
  logic                w_q_bit;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rmd;
  logic [DATA_W-1:0]   w_orig_a;
  logic                w_b_zero;

  assign w_signed_op = ~op[0];
  assign w_abs_a     = f_abs(src_a, w_signed_op);
  assign w_abs_b     = f_abs(src_b, w_signed_op);

  // Multiply step: add multiplicand into the upper half, then shift the whole accumulator right.
  assign w_mul_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + {1'b0, (r_sh[0] ? r_a : '0)};

  // Divide step: bring down the next dividend bit and trial-subtract the divisor.
  // When the subtraction succeeds the true difference is below 2^DATA_W, so the low bits suffice.
  assign w_rem_sh = {r_rem, r_sh[DATA_W-1]};
  assign w_q_bit  = (w_rem_sh >= {1'b0, r_b});
  assign w_diff   = w_rem_sh[DATA_W-1:0] - r_b;

  // Sign fix-up applied once at the end of the iterations.
  assign w_prod   = ((r_op == OP_MULT) && (r_sign_a ^ r_sign_b)) ? -r_acc : r_acc;
  assign w_quo    = f_neg_if(r_sh, (r_op == OP_DIV) && (r_sign_a ^ r_sign_b));
  assign w_rmd    = f_neg_if(r_rem, (r_op == OP_DIV) && r_sign_a);
  assign w_orig_a = f_neg_if(r_a, r_sign_a);
  assign w_b_zero = (r_b == '0);

  // Control FSM together with the iterative datapath and HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_sh     <= '0;
      r_rem    <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Accept: latch op, sign flags and magnitudes; MTHI/MTLO lose to start.
            r_op     <= op;
            r_sign_a <= w_signed_op & src_a[DATA_W-1];
            r_sign_b <= w_signed_op & src_b[DATA_W-1];
            r_a      <= w_abs_a;
            r_b      <= w_abs_b;
            r_sh     <= op[1] ? w_abs_a : w_abs_b;
            r_rem    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end else begin
            if (mthi_we) r_hi <= wdata;
            if (mtlo_we) r_lo <= wdata;
          end
        end
        S_RUN: begin
          if (r_op[1]) begin
            r_rem <= w_q_bit ? w_diff : w_rem_sh[DATA_W-1:0];
            r_sh  <= {r_sh[DATA_W-2:0], w_q_bit};
          end else begin
            r_acc <= {w_mul_sum, r_acc[DATA_W-1:1]};
            r_sh  <= r_sh >> 1;
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_op[1]) begin
            if (w_b_zero) begin
              r_lo <= '1;
              r_hi <= w_orig_a;
            end else begin
              r_lo <= w_quo;
              r_hi <= w_rmd;
            end
          end else begin
            r_hi <= w_prod[2*DATA_W-1:DATA_W];
            r_lo <= w_prod[DATA_W-1:0];
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         mthi_we = 1'b0;
  logic         mtlo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  mult_div_unit #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference: MIPS HI/LO results from plain 64-bit arithmetic. Returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (o == 2'd0) begin
      q = sa * sb;
      return q;
    end
    if (o == 2'd1) begin
      p = ua * ub;
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (o == 2'd2) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    p = ua / ub;
    q = longint'(ua % ub);
    return {q[31:0], p[31:0]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle start pulse; operands are scrambled afterwards.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    cyc(1);
    start = 1'b0;
    op = 2'($urandom); src_a = $urandom; src_b = $urandom;
  endtask

  // Wait (bounded) for done; reports cycles waited and cycles busy was seen high.
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cycles < 200) begin
      cyc(1);
      cycles++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #10;
    n_checks++; if (hi !== 32'h0) begin n_errors++; $display("FAIL reset_hi: got %h expected 00000000", hi); end
    n_checks++; if (lo !== 32'h0) begin n_errors++; $display("FAIL reset_lo: got %h expected 00000000", lo); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu_max();
    int c, bc;
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL multu_busy_start: got %b expected 1", busy); end
    n_checks++; if (lo !== 32'h0) begin n_errors++; $display("FAIL multu_lo_hold: got %h expected 00000000", lo); end
    wait_done(c, bc);
    n_checks++; if (c !== 33) begin n_errors++; $display("FAIL multu_latency: got %0d expected 33", c); end
    n_checks++; if (bc !== 33) begin n_errors++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
    n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
    n_checks++; if (lo !== 32'h0000_0001) begin n_errors++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
    cyc(1);
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_directed();
    logic [1:0]  t_op[6] = '{2'd0, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2};
    logic [31:0] t_a[6]  = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'd100, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] t_b[6]  = '{32'd5, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] t_hi[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h64, 32'h0, 32'hFFFF_FFF9};
    logic [31:0] t_lo[6] = '{32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    int c, bc;
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(c, bc);
      n_checks++; if (c !== 33) begin n_errors++; $display("FAIL directed_latency[%0d]: got %0d expected 33", i, c); end
      n_checks++; if (hi !== t_hi[i]) begin n_errors++; $display("FAIL directed_hi[%0d]: got %h expected %h", i, hi, t_hi[i]); end
      n_checks++; if (lo !== t_lo[i]) begin n_errors++; $display("FAIL directed_lo[%0d]: got %h expected %h", i, lo, t_lo[i]); end
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, v;
    logic [63:0] exp;
    int c, bc;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        v = $urandom;
        wdata = v; mthi_we = 1'b1;
        cyc(1);
        mthi_we = 1'b0;
        n_checks++; if (hi !== v) begin n_errors++; $display("FAIL rand_mthi[%0d]: got %h expected %h", i, hi, v); end
      end
      o = 2'($urandom); a = pick(); b = pick();
      exp = model(o, a, b);
      issue(o, a, b);
      wait_done(c, bc);
      n_checks++; if (c !== 33) begin n_errors++; $display("FAIL rand_latency[%0d]: got %0d expected 33", i, c); end
      n_checks++; if ({hi, lo} !== exp) begin
        n_errors++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h_%h expected %h", i, o, a, b, hi, lo, exp);
      end
    end
  endtask

  task automatic test_interference();
    logic [31:0] pre_hi, pre_lo;
    logic [63:0] exp;
    int c, bc;
    pre_hi = hi; pre_lo = lo;
    exp = model(2'd0, 32'h1234_5678, 32'hFEDC_BA98);
    issue(2'd0, 32'h1234_5678, 32'hFEDC_BA98);
    cyc(4);
    wdata = 32'hDEAD_BEEF; mthi_we = 1'b1;
    cyc(1);
    mthi_we = 1'b0;
    n_checks++; if (hi !== pre_hi) begin n_errors++; $display("FAIL busy_mthi_hi: got %h expected %h", hi, pre_hi); end
    cyc(4);
    op = 2'd3; src_a = 32'd99; src_b = 32'd7; start = 1'b1;
    cyc(1);
    start = 1'b0;
    n_checks++; if (lo !== pre_lo) begin n_errors++; $display("FAIL busy_start_lo: got %h expected %h", lo, pre_lo); end
    wait_done(c, bc);
    n_checks++; if (c !== 23) begin n_errors++; $display("FAIL busy_start_latency: got %0d expected 23", c); end
    n_checks++; if ({hi, lo} !== exp) begin n_errors++; $display("FAIL busy_start_result: got %h_%h expected %h", hi, lo, exp); end
    cyc(2);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL busy_start_idle: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    int c, bc;
    a1 = $urandom; b1 = 32'($urandom_range(1, 1000));
    a2 = $urandom; b2 = $urandom;
    issue(2'd3, a1, b1);
    wait_done(c, bc);
    n_checks++; if ({hi, lo} !== model(2'd3, a1, b1)) begin n_errors++; $display("FAIL b2b_first: got %h_%h expected %h", hi, lo, model(2'd3, a1, b1)); end
    issue(2'd1, a2, b2);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_accept: got %b expected 1", busy); end
    wait_done(c, bc);
    n_checks++; if (c !== 33) begin n_errors++; $display("FAIL b2b_latency: got %0d expected 33", c); end
    n_checks++; if ({hi, lo} !== model(2'd1, a2, b2)) begin n_errors++; $display("FAIL b2b_second: got %h_%h expected %h", hi, lo, model(2'd1, a2, b2)); end
  endtask

  task automatic test_mthi_mtlo();
    wdata = 32'h1234; mthi_we = 1'b1;
    cyc(1);
    mthi_we = 1'b0; wdata = 32'h5678; mtlo_we = 1'b1;
    cyc(1);
    mtlo_we = 1'b0;
    n_checks++; if (hi !== 32'h1234) begin n_errors++; $display("FAIL mthi: got %h expected 00001234", hi); end
    n_checks++; if (lo !== 32'h5678) begin n_errors++; $display("FAIL mtlo: got %h expected 00005678", lo); end
    wdata = 32'h0BAD_F00D; mthi_we = 1'b1; mtlo_we = 1'b1;
    cyc(1);
    mthi_we = 1'b0; mtlo_we = 1'b0;
    n_checks++; if (hi !== 32'h0BAD_F00D) begin n_errors++; $display("FAIL both_hi: got %h expected 0badf00d", hi); end
    n_checks++; if (lo !== 32'h0BAD_F00D) begin n_errors++; $display("FAIL both_lo: got %h expected 0badf00d", lo); end
  endtask

  task automatic test_start_mtlo();
    int c, bc;
    op = 2'd1; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    wdata = 32'hCAFE_F00D; mtlo_we = 1'b1;
    cyc(1);
    start = 1'b0; mtlo_we = 1'b0;
    n_checks++; if (lo !== 32'h0BAD_F00D) begin n_errors++; $display("FAIL start_mtlo_hold: got %h expected 0badf00d", lo); end
    wait_done(c, bc);
    n_checks++; if (lo !== 32'd3000) begin n_errors++; $display("FAIL start_mtlo_lo: got %h expected 00000bb8", lo); end
    n_checks++; if (hi !== 32'd0) begin n_errors++; $display("FAIL start_mtlo_hi: got %h expected 00000000", hi); end
  endtask

  task automatic test_async_reset();
    int c, bc;
    issue(2'd2, 32'hF000_1234, 32'd17);
    cyc(19);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
    n_checks++; if (hi !== 32'h0) begin n_errors++; $display("FAIL arst_hi: got %h expected 00000000", hi); end
    n_checks++; if (lo !== 32'h0) begin n_errors++; $display("FAIL arst_lo: got %h expected 00000000", lo); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL arst_done: got %b expected 0", done); end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(15);
    n_checks++; if ({busy, done, hi, lo} !== 66'h0) begin n_errors++; $display("FAIL arst_no_trace: got busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo); end
    issue(2'd1, 32'd2, 32'd3);
    wait_done(c, bc);
    n_checks++; if (c !== 33) begin n_errors++; $display("FAIL arst_after_latency: got %0d expected 33", c); end
    n_checks++; if (lo !== 32'd6) begin n_errors++; $display("FAIL arst_after_lo: got %h expected 00000006", lo); end
    n_checks++; if (hi !== 32'd0) begin n_errors++; $display("FAIL arst_after_hi: got %h expected 00000000", hi); end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_directed();
    test_random();
    test_interference();
    test_back_to_back();
    test_mthi_mtlo();
    test_start_mtlo();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
